// File: rtl/dsp_mem_arbiter_pkg.sv
// Shared constants and types for the DSP data-memory arbiter.
// Bank select is the top address bit; owner codes tag pending read returns.
package dsp_mem_arbiter_pkg;

    localparam int MEM_ADDR_LEN  = 16;
    localparam int REG_WORD_LEN  = 16;
    localparam int BANK_SEL_BIT  = MEM_ADDR_LEN - 1;
    localparam int BANK_ADDR_LEN = MEM_ADDR_LEN - 1;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_DMA  = 2'd2
    } own_e;

    typedef logic [MEM_ADDR_LEN-1:0]  addr_t;
    typedef logic [BANK_ADDR_LEN-1:0] baddr_t;
    typedef logic [REG_WORD_LEN-1:0]  word_t;

    function automatic logic bank_sel(addr_t a);
        return a[BANK_SEL_BIT];
    endfunction

endpackage

// File: rtl/dsp_mem_arbiter_if.sv
// Requester and bank-side signals of the data-memory arbiter.
// master = core/DMA/RAM environment, slave = arbiter.
interface dsp_mem_arbiter_if;
    import dsp_mem_arbiter_pkg::*;

    logic   core_req;
    logic   core_we;
    addr_t  core_addr;
    word_t  core_wdata;
    logic   core_gnt;
    logic   core_stall;
    logic   core_rvalid;
    word_t  core_rdata;

    logic   dma_req;
    logic   dma_we;
    addr_t  dma_addr;
    word_t  dma_wdata;
    logic   dma_gnt;
    logic   dma_rvalid;
    word_t  dma_rdata;

    logic   b1_en;
    logic   b1_we;
    baddr_t b1_addr;
    word_t  b1_wdata;
    word_t  b1_rdata;

    logic   b2_en;
    logic   b2_we;
    baddr_t b2_addr;
    word_t  b2_wdata;
    word_t  b2_rdata;

    modport master (
        output core_req, core_we, core_addr, core_wdata,
        input  core_gnt, core_stall, core_rvalid, core_rdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_gnt, dma_rvalid, dma_rdata,
        input  b1_en, b1_we, b1_addr, b1_wdata,
        output b1_rdata,
        input  b2_en, b2_we, b2_addr, b2_wdata,
        output b2_rdata
    );

    modport slave (
        input  core_req, core_we, core_addr, core_wdata,
        output core_gnt, core_stall, core_rvalid, core_rdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_gnt, dma_rvalid, dma_rdata,
        output b1_en, b1_we, b1_addr, b1_wdata,
        input  b1_rdata,
        output b2_en, b2_we, b2_addr, b2_wdata,
        input  b2_rdata
    );

endinterface

// File: rtl/dsp_bank_arb.sv
// One bank's arbiter: core priority with bounded DMA starvation,
// strobe mux to the RAM and owner tracking for the read return.
module dsp_bank_arb
    import dsp_mem_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   core_hit,
    input  logic   core_we,
    input  baddr_t core_addr,
    input  word_t  core_wdata,
    input  logic   dma_hit,
    input  logic   dma_we,
    input  baddr_t dma_addr,
    input  word_t  dma_wdata,
    output logic   core_gnt,
    output logic   dma_gnt,
    output logic   b_en,
    output logic   b_we,
    output baddr_t b_addr,
    output word_t  b_wdata,
    input  word_t  b_rdata,
    output logic   core_rvalid,
    output word_t  core_rdata,
    output logic   dma_rvalid,
    output word_t  dma_rdata
);

    localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

    logic [3:0] wait_q, wait_d;
    own_e       own_q, own_d;
    logic       force_dma;

    always_comb begin
        force_dma = core_hit & dma_hit & (wait_q == WAIT_MAX);
        core_gnt  = core_hit & ~force_dma;
        dma_gnt   = dma_hit & ~core_gnt;

        // Counter only survives consecutive denials on this bank.
        wait_d = '0;
        if (dma_hit & ~dma_gnt)
            wait_d = (wait_q == WAIT_MAX) ? wait_q : wait_q + 4'd1;

        b_en    = 1'b0;
        b_we    = 1'b0;
        b_addr  = '0;
        b_wdata = '0;
        own_d   = OWN_NONE;
        unique case (1'b1)
            core_gnt: begin
                b_en    = 1'b1;
                b_we    = core_we;
                b_addr  = core_addr;
                b_wdata = core_wdata;
                own_d   = core_we ? OWN_NONE : OWN_CORE;
            end
            dma_gnt: begin
                b_en    = 1'b1;
                b_we    = dma_we;
                b_addr  = dma_addr;
                b_wdata = dma_wdata;
                own_d   = dma_we ? OWN_NONE : OWN_DMA;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_q <= '0;
            own_q  <= OWN_NONE;
        end else begin
            wait_q <= wait_d;
            own_q  <= own_d;
        end
    end

    assign core_rvalid = (own_q == OWN_CORE);
    assign dma_rvalid  = (own_q == OWN_DMA);
    assign core_rdata  = core_rvalid ? b_rdata : '0;
    assign dma_rdata   = dma_rvalid ? b_rdata : '0;

endmodule

// File: rtl/dsp_mem_arbiter.sv
// Two-requester arbiter for the DSP's two data-memory banks.
// Decodes bank select, runs one arbiter per bank, merges the returns.
module dsp_mem_arbiter
    import dsp_mem_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input logic               clk,
    input logic               rst_n,
    dsp_mem_arbiter_if.slave  bus
);

    logic  c_b2, d_b2;
    logic  c_hit1, c_hit2, d_hit1, d_hit2;
    logic  c_gnt1, c_gnt2, d_gnt1, d_gnt2;
    logic  c_rv1, c_rv2, d_rv1, d_rv2;
    word_t c_rd1, c_rd2, d_rd1, d_rd2;

    assign c_b2   = bank_sel(bus.core_addr);
    assign d_b2   = bank_sel(bus.dma_addr);
    assign c_hit1 = bus.core_req & ~c_b2;
    assign c_hit2 = bus.core_req & c_b2;
    assign d_hit1 = bus.dma_req & ~d_b2;
    assign d_hit2 = bus.dma_req & d_b2;

    dsp_bank_arb #(.MAX_WAIT(MAX_WAIT)) u_b1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .core_hit    (c_hit1),
        .core_we     (bus.core_we),
        .core_addr   (bus.core_addr[BANK_ADDR_LEN-1:0]),
        .core_wdata  (bus.core_wdata),
        .dma_hit     (d_hit1),
        .dma_we      (bus.dma_we),
        .dma_addr    (bus.dma_addr[BANK_ADDR_LEN-1:0]),
        .dma_wdata   (bus.dma_wdata),
        .core_gnt    (c_gnt1),
        .dma_gnt     (d_gnt1),
        .b_en        (bus.b1_en),
        .b_we        (bus.b1_we),
        .b_addr      (bus.b1_addr),
        .b_wdata     (bus.b1_wdata),
        .b_rdata     (bus.b1_rdata),
        .core_rvalid (c_rv1),
        .core_rdata  (c_rd1),
        .dma_rvalid  (d_rv1),
        .dma_rdata   (d_rd1)
    );

    dsp_bank_arb #(.MAX_WAIT(MAX_WAIT)) u_b2 (
        .clk         (clk),
        .rst_n       (rst_n),
        .core_hit    (c_hit2),
        .core_we     (bus.core_we),
        .core_addr   (bus.core_addr[BANK_ADDR_LEN-1:0]),
        .core_wdata  (bus.core_wdata),
        .dma_hit     (d_hit2),
        .dma_we      (bus.dma_we),
        .dma_addr    (bus.dma_addr[BANK_ADDR_LEN-1:0]),
        .dma_wdata   (bus.dma_wdata),
        .core_gnt    (c_gnt2),
        .dma_gnt     (d_gnt2),
        .b_en        (bus.b2_en),
        .b_we        (bus.b2_we),
        .b_addr      (bus.b2_addr),
        .b_wdata     (bus.b2_wdata),
        .b_rdata     (bus.b2_rdata),
        .core_rvalid (c_rv2),
        .core_rdata  (c_rd2),
        .dma_rvalid  (d_rv2),
        .dma_rdata   (d_rd2)
    );

    // A requester owns at most one bank per cycle, so OR-merge is safe.
    assign bus.core_gnt    = c_gnt1 | c_gnt2;
    assign bus.dma_gnt     = d_gnt1 | d_gnt2;
    assign bus.core_stall  = bus.core_req & ~bus.core_gnt;
    assign bus.core_rvalid = c_rv1 | c_rv2;
    assign bus.dma_rvalid  = d_rv1 | d_rv2;
    assign bus.core_rdata  = c_rd1 | c_rd2;
    assign bus.dma_rdata   = d_rd1 | d_rd2;

endmodule

// File: tb/tb_dsp_mem_arbiter.sv
// Scoreboard bench for dsp_mem_arbiter: a per-cycle arbitration model
// queues expected strobes and read returns; a monitor compares them.
module tb_dsp_mem_arbiter;

    localparam int MAX_WAIT = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   vectors = 0;
    int   fails = 0;
    bit   run = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dsp_mem_arbiter_if bus ();

    dsp_mem_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        int                cyc;
        logic              cg, cs, dg;
        logic [1:0]        en, we;
        logic [1:0][14:0]  addr;
        logic [1:0][15:0]  wd;
    } exp_t;

    typedef struct {
        int          cyc;
        logic [15:0] data;
    } ret_t;

    exp_t eq[$];
    ret_t rq_c[$];
    ret_t rq_d[$];
    int   denied[2];

    // Bank contents are a fixed function of bank and word address.
    function automatic logic [15:0] ram_val(int k, logic [14:0] a);
        return (k != 0 ? 16'h5A5A : 16'hA5A5) ^ {a, 1'b1};
    endfunction

    // Synchronous RAMs; junk on non-read cycles exposes unmasked rdata.
    always @(posedge clk) begin
        bus.b1_rdata <= (bus.b1_en && !bus.b1_we) ? ram_val(0, bus.b1_addr)
                                                  : 16'($urandom);
        bus.b2_rdata <= (bus.b2_en && !bus.b2_we) ? ram_val(1, bus.b2_addr)
                                                  : 16'($urandom);
    end

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at cycle %0d",
                     n, act, exp, cyc);
        end
    endtask

    task automatic drive(input logic cr, input logic cw,
                         input logic [15:0] ca, input logic [15:0] cd,
                         input logic dr, input logic dw,
                         input logic [15:0] da, input logic [15:0] dd);
        exp_t e;
        @(posedge clk);
        #1;
        bus.core_req   = cr;
        bus.core_we    = cw;
        bus.core_addr  = ca;
        bus.core_wdata = cd;
        bus.dma_req    = dr;
        bus.dma_we     = dw;
        bus.dma_addr   = da;
        bus.dma_wdata  = dd;
        e = '{cyc: cyc, cg: 0, cs: 0, dg: 0, en: '0, we: '0,
              addr: '0, wd: '0};
        for (int k = 0; k < 2; k++) begin
            bit ch, dh, cwin, dwin;
            ch   = cr && (int'(ca[15]) == k);
            dh   = dr && (int'(da[15]) == k);
            cwin = ch && !(dh && denied[k] >= MAX_WAIT);
            dwin = dh && !cwin;
            if (dh && !dwin)
                denied[k] = (denied[k] < MAX_WAIT) ? denied[k] + 1 : MAX_WAIT;
            else
                denied[k] = 0;
            if (cwin) begin
                e.cg = 1; e.en[k] = 1; e.we[k] = cw;
                e.addr[k] = ca[14:0]; e.wd[k] = cd;
                if (!cw) rq_c.push_back('{cyc + 1, ram_val(k, ca[14:0])});
            end
            if (dwin) begin
                e.dg = 1; e.en[k] = 1; e.we[k] = dw;
                e.addr[k] = da[14:0]; e.wd[k] = dd;
                if (!dw) rq_d.push_back('{cyc + 1, ram_val(k, da[14:0])});
            end
        end
        e.cs = cr && !e.cg;
        eq.push_back(e);
    endtask

    task automatic idle();
        drive(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
    endtask

    // Reset lands late in the current cycle, dropping any pending return.
    task automatic pulse_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        rq_c.delete();
        rq_d.delete();
        denied[0] = 0;
        denied[1] = 0;
        idle();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (run) begin
            bit ec, ed;
            ec = rq_c.size() > 0 && rq_c[0].cyc == cyc;
            ed = rq_d.size() > 0 && rq_d[0].cyc == cyc;
            chk("core_rvalid", 32'(bus.core_rvalid), 32'(ec));
            chk("core_rdata", 32'(bus.core_rdata), ec ? 32'(rq_c[0].data) : 0);
            chk("dma_rvalid", 32'(bus.dma_rvalid), 32'(ed));
            chk("dma_rdata", 32'(bus.dma_rdata), ed ? 32'(rq_d[0].data) : 0);
            if (ec) void'(rq_c.pop_front());
            if (ed) void'(rq_d.pop_front());
            if (eq.size() > 0 && eq[0].cyc == cyc) begin
                exp_t e;
                e = eq.pop_front();
                chk("core_gnt", 32'(bus.core_gnt), 32'(e.cg));
                chk("core_stall", 32'(bus.core_stall), 32'(e.cs));
                chk("dma_gnt", 32'(bus.dma_gnt), 32'(e.dg));
                chk("b1_strobe",
                    {bus.b1_en, bus.b1_we, bus.b1_addr, bus.b1_wdata},
                    {e.en[0], e.we[0], e.addr[0], e.wd[0]});
                chk("b2_strobe",
                    {bus.b2_en, bus.b2_we, bus.b2_addr, bus.b2_wdata},
                    {e.en[1], e.we[1], e.addr[1], e.wd[1]});
            end
        end
    end

    initial begin
        bus.core_req = 0; bus.core_we = 0; bus.core_addr = 0;
        bus.core_wdata = 0;
        bus.dma_req = 0; bus.dma_we = 0; bus.dma_addr = 0;
        bus.dma_wdata = 0;
        denied[0] = 0;
        denied[1] = 0;
        run = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        drive(1, 0, 16'h0010, 16'h0, 0, 0, 16'h0, 16'h0);
        idle();
        drive(1, 0, 16'h0004, 16'h0, 1, 1, 16'h8004, 16'h1234);
        idle();

        repeat (7) drive(1, 0, 16'h8000, 16'h0, 1, 0, 16'h8000, 16'h0);
        idle();

        repeat (2) drive(1, 1, 16'h8002, 16'h7777, 1, 0, 16'h8003, 16'h0);
        drive(1, 1, 16'h8002, 16'h7777, 0, 0, 16'h8003, 16'h0);
        repeat (6) drive(1, 1, 16'h8002, 16'h7777, 1, 0, 16'h8003, 16'h0);
        idle();

        drive(0, 0, 16'h0, 16'h0, 1, 0, 16'h8020, 16'h0);
        pulse_reset();
        idle();

        for (int i = 0; i < 8; i++)
            drive(1, 0, {i[0], 15'(16 + i)}, 16'h0, 0, 0, 16'h0, 16'h0);
        idle();

        for (int i = 0; i < 400; i++) begin
            logic        cr, dr, cw, dw, cb, db;
            cr = $urandom_range(0, 3) != 0;
            dr = $urandom_range(0, 3) != 0;
            cw = $urandom_range(0, 2) == 0;
            dw = $urandom_range(0, 2) == 0;
            cb = 1'($urandom_range(0, 1));
            db = ($urandom_range(0, 2) == 0) ? ~cb : cb;
            drive(cr, cw, {cb, 15'($urandom_range(0, 255))}, 16'($urandom),
                  dr, dw, {db, 15'($urandom_range(0, 255))}, 16'($urandom));
        end

        repeat (3) idle();
        @(negedge clk);
        #1;
        chk("drain", 32'(rq_c.size() + rq_d.size() + eq.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/dsp_mem_arbiter.md
# dsp_mem_arbiter

Two-requester arbiter in front of the DSP's two data-memory banks. It shares the banks between the core memory stage (LD/ST traffic) and the receiver sample DMA (streaming sample writes and coefficient reads). Bank 1 is selected by address bit 15 = 0 and bank 2 by bit 15 = 1. The block grants each bank to one requester per cycle, stalls the core on conflict, bounds DMA starvation, and routes the 1-cycle-latency read data back to whichever requester owned the bank.

## Interface
- `MEM_ADDR_LEN`, 16, requester address width; bit `MEM_ADDR_LEN-1` selects the bank.
- `REG_WORD_LEN`, 16, data word width.
- `MAX_WAIT`, 4, consecutive denied DMA cycles on one bank before DMA is forced to win it (range 1..15).
- `clk` input 1 — single clock, all state on rising edge.
- `rst_n` input 1 — asynchronous reset, active low.
- `core_req`/`core_we` input 1/1 — core access request and write flag.
- `core_addr` input `MEM_ADDR_LEN` — core address.
- `core_wdata` input `REG_WORD_LEN` — core store data.
- `core_gnt` output 1 — core access performed this cycle.
- `core_stall` output 1 — equals `core_req & ~core_gnt`.
- `core_rvalid` output 1 — core read data valid.
- `core_rdata` output `REG_WORD_LEN` — core read data.
- `dma_req`, `dma_we`, `dma_addr`, `dma_wdata`, `dma_gnt`, `dma_rvalid`, `dma_rdata` — same meaning as the core port. DMA has no stall output; it holds its request until granted.
- `b1_en`/`b1_we` output 1/1 — bank 1 strobe and write enable.
- `b1_addr` output `MEM_ADDR_LEN-1` — bank 1 word address (requester `addr[MEM_ADDR_LEN-2:0]`).
- `b1_wdata` output `REG_WORD_LEN` / `b1_rdata` input `REG_WORD_LEN` — bank 1 write and read data. The bank is a synchronous RAM: read data appears the cycle after `b1_en & ~b1_we`.
- `b2_*` — identical set for bank 2.

## Operation
- Each bank has an independent arbiter with a wait counter `wait_cnt` (4 bits) and a registered owner state `own` ∈ {OWN_NONE, OWN_CORE, OWN_DMA}.
- Request targets bank k when `addr[MEM_ADDR_LEN-1]` = k-1. Read and write requests are arbitrated identically.
- Per bank, per cycle:
  - Only one requester targets the bank: that requester is granted.
  - Both target the bank and `wait_cnt < MAX_WAIT`: the core wins and the DMA is denied.
  - Both target the bank and `wait_cnt == MAX_WAIT`: the DMA wins and `core_stall` = 1.
- Requests to different banks are both granted in the same cycle.
- `wait_cnt` is updated per bank:
  - +1 when a DMA request to the bank is denied (saturates at `MAX_WAIT`).
  - Cleared when the DMA is granted that bank, or when `dma_req` is low or targets the other bank.
- Bank outputs are driven from the winner: `bX_en = 1`, `bX_we`/`bX_addr`/`bX_wdata` from the winner's request. With no winner, `bX_en = 0`, `bX_we = 0`, and addr/data = 0.
- `own` next state:
  - OWN_CORE if the core won a read on that bank.
  - OWN_DMA if the DMA won a read.
  - OWN_NONE otherwise, including writes.
- Read return, next cycle: `own == OWN_CORE` gives `core_rvalid = 1` with `core_rdata = bX_rdata`. OWN_DMA does the same on the DMA port. With no valid return, rdata = 0.
- At most one bank returns to a given requester per cycle, because each requester issues one request per cycle.

## Timing
- Grant, stall and bank strobes are combinational from the requests in the same cycle. The bank strobe is not registered.
- Read latency from grant to `rvalid`/`rdata` is exactly 1 cycle. Writes produce no response.
- Back-to-back reads every cycle are supported on both ports.
- Reset values: `wait_cnt = 0`, `own = OWN_NONE`, `core_rvalid = dma_rvalid = 0`, all rdata = 0. Gnt, stall and bank strobes are 0 whenever the requests are 0.
- Reset asserted mid-read: a pending return is dropped and `rvalid` is 0 the cycle after reset releases.
- A forced DMA win takes exactly `MAX_WAIT` denied cycles: the DMA is granted on the (`MAX_WAIT`+1)th cycle of continuous conflict.
- The core re-wins on the following cycle, and the counter restarts from 0.

## Structure
- Shared constants go in `definitions.v`: `MEM_ADDR_LEN`, `REG_WORD_LEN`, `BANK_SEL_BIT`, and the owner encodings `OWN_NONE`=2'd0, `OWN_CORE`=2'd1, `OWN_DMA`=2'd2.
- Sub-module `dsp_bank_arb` contains one bank's arbitration, wait counter, owner register and strobe mux. It is instantiated twice.
- The top level decodes bank select, ORs the grants, and merges the read returns.

## Test plan
- Core read to 0x0010 alone, with bank 1 returning 0xBEEF → `core_gnt=1`, `b1_en=1`, `b1_addr=0x0010`; next cycle `core_rvalid=1`, `core_rdata=0xBEEF`.
- Core read 0x0004 and DMA write 0x8004=0x1234 in the same cycle → both granted, `b1_en=b2_en=1`, `b2_we=1`, `b2_wdata=0x1234`, no stall.
- Core and DMA both request 0x8000 continuously, `MAX_WAIT=4` → core granted cycles 0–3, DMA granted cycle 4 with `core_stall=1`, core granted again at cycle 5.
- DMA denied 2 cycles, then `dma_req` dropped 1 cycle, then conflict resumes → counter restarts; DMA is not forced until 4 fresh denials.
- DMA read 0x8020 granted, then `rst_n` pulsed low before the edge → no `dma_rvalid`; all outputs at reset values.
- Alternating core reads to bank 1 and bank 2 every cycle → `core_rvalid` high every cycle after the first, with data from the correct bank.
